// File: rtl/debug_pkg.sv
// Command words, halt marker and state encoding shared by the debug controller and its dump sequencer.
package debug_pkg;

  typedef enum logic [3:0] {
    IDLE, DECODE, LOAD, RUN, STEP_WAIT, STEP_PULSE,
    DUMP_REG, DUMP_MEM, DUMP_LAT, SEND_TAIL
  } state_t;

  localparam logic [31:0] CMD_RINS    = "rins";
  localparam logic [31:0] CMD_CONT    = "cont";
  localparam logic [31:0] CMD_STEP    = "step";
  localparam logic [31:0] CMD_NEXT    = "next";
  localparam logic [31:0] CMD_FPIP    = "fpip";
  localparam logic [31:0] CMD_IEOF    = "ieof";
  localparam logic [31:0] CMD_STOP    = "stop";
  localparam logic [31:0] CMD_ERR     = "err?";
  localparam logic [31:0] CMD_OVFL    = "ovfl";
  localparam logic [31:0] HALT_MARKER = 32'hFFFF_FFFF;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/debug_dump_seq.sv
// Walks registers, data memory and pipeline latches, offering one word at a time to the transmitter.
// Each word needs one cycle of stable address before it is offered; advances only when the offer is taken.
module debug_dump_seq
  import debug_pkg::*;
#(
  parameter int WORD_W         = 32,
  parameter int REG_ADDR_BITS  = 5,
  parameter int DMEM_ADDR_BITS = 8,
  parameter int LATCH_WORDS    = 12
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          start,
  input  logic                          tx_ok,
  input  logic [WORD_W-1:0]             reg_data,
  input  logic [WORD_W-1:0]             dmem_data,
  input  logic [LATCH_WORDS*WORD_W-1:0] latches,
  output state_t                        next_phase,
  output logic                          done,
  output logic                          tx_req,
  output logic [WORD_W-1:0]             tx_word,
  output logic [REG_ADDR_BITS-1:0]      reg_addr,
  output logic [DMEM_ADDR_BITS-1:0]     dmem_addr
);

  localparam int LAT_BITS = $clog2(LATCH_WORDS + 1);
  localparam int AW       = (REG_ADDR_BITS > DMEM_ADDR_BITS) ? REG_ADDR_BITS : DMEM_ADDR_BITS;
  localparam int CW       = ((AW > LAT_BITS) ? AW : LAT_BITS) + 1;

  state_t        phase;
  logic [CW-1:0] cnt, cnt_inc, phase_len;
  logic          primed, fire, last;
  logic [WORD_W-1:0] lat_word;

  assign cnt_inc  = cnt + CW'(1);
  assign tx_req   = primed && (phase != IDLE);
  assign fire     = tx_req && tx_ok;
  assign last     = (cnt_inc == phase_len);
  assign done     = fire && last && (phase == DUMP_LAT);
  assign reg_addr  = (phase == DUMP_REG) ? cnt[REG_ADDR_BITS-1:0] : '0;
  assign dmem_addr = (phase == DUMP_MEM) ? cnt[DMEM_ADDR_BITS-1:0] : '0;

  always_comb begin
    lat_word = '0;
    for (int k = 0; k < LATCH_WORDS; k++) begin
      if (cnt == CW'(k)) lat_word = latches[k*WORD_W +: WORD_W];
    end
  end

  always_comb begin
    phase_len  = CW'(LATCH_WORDS);
    tx_word    = lat_word;
    next_phase = phase;
    case (phase)
      DUMP_REG: begin phase_len = CW'(1) << REG_ADDR_BITS;  tx_word = reg_data;  end
      DUMP_MEM: begin phase_len = CW'(1) << DMEM_ADDR_BITS; tx_word = dmem_data; end
      default: ;
    endcase
    if (start) begin
      next_phase = DUMP_REG;
    end else if (fire && last) begin
      case (phase)
        DUMP_REG: next_phase = DUMP_MEM;
        DUMP_MEM: next_phase = DUMP_LAT;
        default:  next_phase = IDLE;
      endcase
    end
  end

  // primed marks that the address has been stable for a cycle, so read data is current
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      phase  <= IDLE;
      cnt    <= '0;
      primed <= 1'b0;
    end else begin
      phase <= next_phase;
      if (start) begin
        cnt    <= '0;
        primed <= 1'b0;
      end else if (fire) begin
        cnt    <= last ? '0 : cnt_inc;
        primed <= 1'b0;
      end else begin
        primed <= (phase != IDLE);
      end
    end
  end

endmodule

// File: rtl/uart_debug_controller.sv
// Command decoder for the UART debug link: loads instruction memory, runs/steps the core and dumps state.
// Transmit words are registered and never issued on back-to-back cycles; receive words outside listening states are dropped.
module uart_debug_controller
  import debug_pkg::*;
#(
  parameter int WORD_W         = 32,
  parameter int REG_ADDR_BITS  = 5,
  parameter int DMEM_ADDR_BITS = 8,
  parameter int IMEM_ADDR_BITS = 6,
  parameter int LATCH_WORDS    = 12
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic [WORD_W-1:0]             i_rx_word,
  input  logic                          i_rx_valid,
  output logic [WORD_W-1:0]             o_tx_word,
  output logic                          o_tx_valid,
  input  logic                          i_tx_ready,
  output logic [REG_ADDR_BITS-1:0]      o_reg_addr,
  input  logic [WORD_W-1:0]             i_reg_data,
  output logic [DMEM_ADDR_BITS-1:0]     o_dmem_addr,
  input  logic [WORD_W-1:0]             i_dmem_data,
  input  logic [LATCH_WORDS*WORD_W-1:0] i_latches,
  output logic                          o_imem_wr_en,
  output logic [IMEM_ADDR_BITS-1:0]     o_imem_wr_addr,
  output logic [WORD_W-1:0]             o_imem_wr_data,
  output logic                          o_run,
  output logic                          o_step,
  input  logic                          i_halted,
  output logic                          o_busy
);

  localparam logic [IMEM_ADDR_BITS:0] LOAD_FULL = {1'b1, {IMEM_ADDR_BITS{1'b0}}};

  state_t state, state_nxt, dump_phase_nxt;
  logic [WORD_W-1:0]       cmd_q, tail_w0, tail_w1, tail_a, tail_b, issue_word, dump_tx_word;
  logic [IMEM_ADDR_BITS:0] load_addr;
  logic [31:0]             cyc_cnt, cyc_inc;
  logic [1:0]              tail_left, tail_n;
  logic from_step, tail_set, wr_fire, load_clr, cyc_clr, dump_start, dump_active;
  logic tx_ok, issue, dump_tx_req, dump_done;

  assign cyc_inc     = sat_inc(cyc_cnt);
  assign tx_ok       = i_tx_ready && !o_tx_valid;
  assign dump_active = (state == DUMP_REG) || (state == DUMP_MEM) || (state == DUMP_LAT);
  assign issue       = tx_ok && ((state == SEND_TAIL) || (dump_active && dump_tx_req));
  assign issue_word  = (state == SEND_TAIL) ? tail_w0 : dump_tx_word;
  assign o_run       = (state == RUN);
  assign o_step      = (state == STEP_PULSE);
  assign o_busy      = (state != IDLE);

  always_comb begin
    state_nxt  = state;
    tail_set   = 1'b0;
    tail_a     = '0;
    tail_b     = '0;
    tail_n     = 2'd0;
    wr_fire    = 1'b0;
    load_clr   = 1'b0;
    cyc_clr    = 1'b0;
    dump_start = 1'b0;
    case (state)
      IDLE: if (i_rx_valid) state_nxt = DECODE;
      DECODE: begin
        if (cmd_q == WORD_W'(CMD_RINS)) begin
          state_nxt = LOAD;
          load_clr  = 1'b1;
        end else if (cmd_q == WORD_W'(CMD_CONT)) begin
          state_nxt = RUN;
          cyc_clr   = 1'b1;
        end else if (cmd_q == WORD_W'(CMD_STEP)) begin
          state_nxt = STEP_WAIT;
        end else if (cmd_q == WORD_W'(CMD_FPIP)) begin
          state_nxt  = DUMP_REG;
          dump_start = 1'b1;
        end else begin
          state_nxt = SEND_TAIL;
          tail_set  = 1'b1;
          tail_a    = WORD_W'(CMD_ERR);
          tail_n    = 2'd1;
        end
      end
      LOAD: if (i_rx_valid) begin
        if (i_rx_word == WORD_W'(CMD_IEOF)) begin
          state_nxt = SEND_TAIL;
          tail_set  = 1'b1;
          tail_a    = WORD_W'(load_addr);
          tail_n    = 2'd1;
        end else if (load_addr == LOAD_FULL) begin
          state_nxt = SEND_TAIL;
          tail_set  = 1'b1;
          tail_a    = WORD_W'(CMD_OVFL);
          tail_n    = 2'd1;
        end else begin
          wr_fire = 1'b1;
        end
      end
      // the exit cycle is itself a RUN cycle, so the reported count includes it
      RUN: if (i_halted || (i_rx_valid && i_rx_word == WORD_W'(CMD_STOP))) begin
        state_nxt = SEND_TAIL;
        tail_set  = 1'b1;
        tail_a    = i_halted ? WORD_W'(HALT_MARKER) : WORD_W'(CMD_STOP);
        tail_b    = WORD_W'(cyc_inc);
        tail_n    = 2'd2;
      end
      STEP_WAIT: begin
        if (i_halted) begin
          state_nxt = SEND_TAIL;
          tail_set  = 1'b1;
          tail_a    = WORD_W'(HALT_MARKER);
          tail_n    = 2'd1;
        end else if (i_rx_valid && i_rx_word == WORD_W'(CMD_NEXT)) begin
          state_nxt = STEP_PULSE;
        end else if (i_rx_valid && i_rx_word == WORD_W'(CMD_STOP)) begin
          state_nxt = SEND_TAIL;
          tail_set  = 1'b1;
          tail_a    = WORD_W'(CMD_STOP);
          tail_n    = 2'd1;
        end
      end
      STEP_PULSE: begin
        state_nxt  = DUMP_REG;
        dump_start = 1'b1;
      end
      DUMP_REG, DUMP_MEM, DUMP_LAT:
        state_nxt = dump_done ? (from_step ? STEP_WAIT : IDLE) : dump_phase_nxt;
      SEND_TAIL: if (tx_ok && tail_left == 2'd1) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state          <= IDLE;
      cmd_q          <= '0;
      load_addr      <= '0;
      cyc_cnt        <= '0;
      tail_w0        <= '0;
      tail_w1        <= '0;
      tail_left      <= '0;
      from_step      <= 1'b0;
      o_imem_wr_en   <= 1'b0;
      o_imem_wr_addr <= '0;
      o_imem_wr_data <= '0;
      o_tx_valid     <= 1'b0;
      o_tx_word      <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && i_rx_valid) cmd_q <= i_rx_word;
      if (load_clr) load_addr <= '0;
      else if (wr_fire) load_addr <= load_addr + (IMEM_ADDR_BITS+1)'(1);
      o_imem_wr_en <= wr_fire;
      if (wr_fire) begin
        o_imem_wr_addr <= load_addr[IMEM_ADDR_BITS-1:0];
        o_imem_wr_data <= i_rx_word;
      end
      if (cyc_clr) cyc_cnt <= '0;
      else if (state == RUN) cyc_cnt <= cyc_inc;
      if (tail_set) begin
        tail_w0   <= tail_a;
        tail_w1   <= tail_b;
        tail_left <= tail_n;
      end else if (state == SEND_TAIL && tx_ok) begin
        tail_w0   <= tail_w1;
        tail_w1   <= '0;
        tail_left <= tail_left - 2'd1;
      end
      if (dump_start) from_step <= (state == STEP_PULSE);
      o_tx_valid <= issue;
      if (issue) o_tx_word <= issue_word;
    end
  end

  debug_dump_seq #(
    .WORD_W(WORD_W), .REG_ADDR_BITS(REG_ADDR_BITS),
    .DMEM_ADDR_BITS(DMEM_ADDR_BITS), .LATCH_WORDS(LATCH_WORDS)
  ) u_dump (
    .i_clk(i_clk), .i_reset(i_reset), .start(dump_start), .tx_ok(tx_ok),
    .reg_data(i_reg_data), .dmem_data(i_dmem_data), .latches(i_latches),
    .next_phase(dump_phase_nxt), .done(dump_done), .tx_req(dump_tx_req),
    .tx_word(dump_tx_word), .reg_addr(o_reg_addr), .dmem_addr(o_dmem_addr)
  );

endmodule
